memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage_pkg.sv | 27 ++
 rtl/memory_stage_load_align.sv | 29 ++
 rtl/memory_stage.sv | 183 ++++++++++++++++++
 tb/tb_memory_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// Shared types for the memory stage: access width encoding, FSM states and alignment rule.
package memory_stage_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_width_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_e;

  // Width code 2'b11 is reserved and always reported as misaligned.
  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] offset);
    case (width)
      BYTE:    is_misaligned = 1'b0;
      HALF:    is_misaligned = offset[0];
      WORD:    is_misaligned = (offset != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/memory_stage_load_align.sv
// Combinational load lane extraction with optional sign extension.
module load_align
  import memory_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      offset_i,
  input  logic [1:0]      width_i,
  input  logic            sign_ext_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  assign byteLane = 8'(rdata_i >> {offset_i, 3'b000});
  assign halfLane = 16'(rdata_i >> {offset_i, 3'b000});

  always_comb begin
    data_o = rdata_i;
    case (width_i)
      BYTE:    data_o = {{(XLEN-8){sign_ext_i & byteLane[7]}}, byteLane};
      HALF:    data_o = {{(XLEN-16){sign_ext_i & halfLane[15]}}, halfLane};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: accepts one load/store, runs it on a simple gnt/rvalid bus, pulses resp_valid.
// Optional bus wait timeout is enabled by defining MEMORY_STAGE_TIMEOUT_EN.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read_en,
  input  logic              mem_write_en,
  input  logic              sign_extend,
  input  logic [1:0]        mem_width,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   valM,
  output logic              mem_fault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_wstrb,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [XLEN-1:0]   bus_rdata
);

  localparam int STRB_W = XLEN / 8;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [1:0]        width_q, width_d;
  logic              signExt_q, signExt_d;
  logic              isWrite_q, isWrite_d;
  logic [XLEN-1:0]   valM_q, valM_d;
  logic              fault_q, fault_d;
  logic [XLEN-1:0]   loadData;
  logic [STRB_W-1:0] strbBase;
  logic              inReq;
  logic              timeoutHit;

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata_i    (bus_rdata),
    .offset_i   (addr_q[1:0]),
    .width_i    (width_q),
    .sign_ext_i (signExt_q),
    .data_o     (loadData)
  );

`ifdef MEMORY_STAGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] count_q, count_d;

  // One budget covers REQ and WAIT together; it saturates once the limit is reached.
  always_comb begin
    count_d = count_q;
    if (state_q == IDLE) begin
      count_d = '0;
    end else if ((state_q == REQ || state_q == WAIT) && count_q != CNT_W'(TIMEOUT_CYCLES)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign timeoutHit = (count_q >= CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unusedTimeoutCfg;
  assign unusedTimeoutCfg = (TIMEOUT_CYCLES != 0);
  assign timeoutHit       = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    width_d   = width_q;
    signExt_d = signExt_q;
    isWrite_d = isWrite_q;
    valM_d    = valM_q;
    fault_d   = fault_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d    = addr;
          wdata_d   = wdata;
          width_d   = mem_width;
          signExt_d = sign_extend;
          isWrite_d = mem_write_en;
          if (!mem_read_en && !mem_write_en) begin
            state_d = RESP;
            valM_d  = '0;
            fault_d = 1'b0;
          end else if ((mem_read_en && mem_write_en) || is_misaligned(mem_width, addr[1:0])) begin
            state_d = RESP;
            valM_d  = '0;
            fault_d = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (bus_gnt) begin
          state_d = isWrite_q ? RESP : WAIT;
          if (isWrite_q) begin
            valM_d  = '0;
            fault_d = 1'b0;
          end
        end else if (timeoutHit) begin
          state_d = RESP;
          valM_d  = '0;
          fault_d = 1'b1;
        end
      end
      WAIT: begin
        if (bus_rvalid) begin
          state_d = RESP;
          valM_d  = loadData;
          fault_d = 1'b0;
        end else if (timeoutHit) begin
          state_d = RESP;
          valM_d  = '0;
          fault_d = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      width_q   <= 2'b00;
      signExt_q <= 1'b0;
      isWrite_q <= 1'b0;
      valM_q    <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      width_q   <= width_d;
      signExt_q <= signExt_d;
      isWrite_q <= isWrite_d;
      valM_q    <= valM_d;
      fault_q   <= fault_d;
    end
  end

  // Bus outputs are forced to zero outside REQ so nothing leaks onto an idle bus.
  always_comb begin
    strbBase = STRB_W'(4'b1111);
    case (width_q)
      BYTE:    strbBase = STRB_W'(4'b0001);
      HALF:    strbBase = STRB_W'(4'b0011);
      default: strbBase = STRB_W'(4'b1111);
    endcase
  end

  assign inReq      = (state_q == REQ);
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign valM       = valM_q;
  assign mem_fault  = fault_q;
  assign bus_req    = inReq;
  assign bus_we     = inReq & isWrite_q;
  assign bus_addr   = inReq ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign bus_wdata  = inReq ? (wdata_q << {addr_q[1:0], 3'b000}) : '0;
  assign bus_wstrb  = (inReq && isWrite_q) ? (strbBase << addr_q[1:0]) : '0;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed cases plus randomized traffic against a byte-level model.
// Timeout cases run only when MEMORY_STAGE_TIMEOUT_EN is defined.
module tb_memory_stage;

  localparam int XLEN = 32;
  localparam int TO   = 4;
`ifdef MEMORY_STAGE_TIMEOUT_EN
  localparam int MAX_GNT_RD = 1;
  localparam int MAX_RV     = 1;
`else
  localparam int MAX_GNT_RD = 3;
  localparam int MAX_RV     = 3;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            mem_read_en = 1'b0;
  logic            mem_write_en = 1'b0;
  logic            sign_extend = 1'b0;
  logic [1:0]      mem_width = 2'b00;
  logic [XLEN-1:0] addr = '0;
  logic [XLEN-1:0] wdata = '0;
  logic            resp_valid;
  logic [XLEN-1:0] valM;
  logic            mem_fault;
  logic            bus_req;
  logic            bus_we;
  logic [XLEN-1:0] bus_addr;
  logic [XLEN-1:0] bus_wdata;
  logic [3:0]      bus_wstrb;
  logic            bus_gnt = 1'b0;
  logic            bus_rvalid = 1'b0;
  logic [XLEN-1:0] bus_rdata = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  memory_stage #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .sign_extend(sign_extend),
    .mem_width(mem_width), .addr(addr), .wdata(wdata), .resp_valid(resp_valid),
    .valM(valM), .mem_fault(mem_fault), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  // Reference model: 0 no-op, 1 fault, 2 write, 3 read.
  function automatic int model_kind(input logic rd, input logic wr, input logic [1:0] w, input logic [31:0] a);
    int size;
    size = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    if (!rd && !wr) return 0;
    if ((rd && wr) || w == 2'd3 || (a % size) != 0) return 1;
    return wr ? 2 : 3;
  endfunction

  function automatic logic [3:0] model_strb(input logic [1:0] w, input logic [31:0] a);
    int size;
    size = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    return 4'(((1 << size) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [31:0] a);
    longint v;
    v = longint'(wd) << (8 * (a % 4));
    return 32'(v);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdat, input logic [1:0] w, input logic sx, input logic [31:0] a);
    int size;
    longint v;
    size = (w == 2'd0) ? 1 : 2;
    if (w == 2'd2) return rdat;
    v = (longint'(rdat) >> (8 * (a % 4))) & ((64'sd1 << (8 * size)) - 1);
    if (sx && v >= (64'sd1 << (8 * size - 1))) v = v - (64'sd1 << (8 * size));
    return 32'(v);
  endfunction

  // Drives one request and plays the bus side; returns what was observed, compares nothing.
  task automatic run_txn(
    input  logic rd, input logic wr, input logic sx, input logic [1:0] w,
    input  logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
    input  int gd, input int rvd,
    output int lat, output int reqCyc, output logic [31:0] oAddr, output logic [31:0] oWdata,
    output logic [3:0] oStrb, output logic oWe, output logic [31:0] oValM, output logic oFault,
    output logic gotResp, output logic respOne, output logic idleReady, output logic strayBus);
    int   waitCyc;
    logic granted;
    waitCyc = 0; granted = 1'b0; lat = 0; reqCyc = 0;
    oAddr = '0; oWdata = '0; oStrb = '0; oWe = 1'b0; oValM = '0; oFault = 1'b0;
    gotResp = 1'b0; respOne = 1'b0; idleReady = 1'b0; strayBus = 1'b0;
    @(negedge clk);
    mem_read_en = rd; mem_write_en = wr; sign_extend = sx; mem_width = w;
    addr = a; wdata = wd; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    mem_read_en = 1'($urandom); mem_write_en = 1'($urandom); sign_extend = 1'($urandom);
    mem_width = 2'($urandom); addr = $urandom; wdata = $urandom;
    lat = 1;
    while (!gotResp && lat < 100) begin
      if (resp_valid) begin
        gotResp = 1'b1; oValM = valM; oFault = mem_fault;
      end else begin
        if (bus_req) begin
          reqCyc++;
          oAddr = bus_addr; oWdata = bus_wdata; oStrb = bus_wstrb; oWe = bus_we;
          bus_gnt = (reqCyc > gd);
          granted = bus_gnt;
          bus_rvalid = 1'($urandom_range(0, 1));
          bus_rdata = $urandom;
        end else begin
          if (bus_we || bus_wstrb != 4'd0) strayBus = 1'b1;
          bus_gnt = 1'($urandom_range(0, 1));
          if (granted) begin
            waitCyc++;
            bus_rvalid = (waitCyc > rvd);
            bus_rdata = bus_rvalid ? rdat : $urandom;
          end
        end
        @(negedge clk);
        lat++;
      end
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    if (gotResp) begin
      @(negedge clk);
      respOne = !resp_valid;
      idleReady = req_ready;
    end
  endtask

  int lat, reqCyc;
  logic [31:0] oAddr, oWdata, oValM;
  logic [3:0] oStrb;
  logic oWe, oFault, gotResp, respOne, idleReady, strayBus;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({req_ready, resp_valid, mem_fault, bus_req, bus_we} !== 5'b10000) begin
      miscompares++; $display("FAIL reset_ctrl: got %b expected 10000", {req_ready, resp_valid, mem_fault, bus_req, bus_we});
    end
    vectors++;
    if (valM !== 32'd0) begin miscompares++; $display("FAIL reset_valM: got %h expected 0", valM); end
    vectors++;
    if (bus_wstrb !== 4'd0) begin miscompares++; $display("FAIL reset_wstrb: got %b expected 0000", bus_wstrb); end
    vectors++;
    if (bus_addr !== 32'd0 || bus_wdata !== 32'd0) begin
      miscompares++; $display("FAIL reset_bus: addr %h wdata %h expected 0", bus_addr, bus_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_release: ready %b resp %b expected 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_write();
    run_txn(1'b0, 1'b1, 1'b0, 2'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0,
            lat, reqCyc, oAddr, oWdata, oStrb, oWe, oValM, oFault, gotResp, respOne, idleReady, strayBus);
    vectors++;
    if (lat !== 2 || oFault !== 1'b0) begin miscompares++; $display("FAIL wr_word_lat: lat %0d fault %b expected 2 0", lat, oFault); end
    vectors++;
    if (oAddr !== 32'h100 || oStrb !== 4'b1111) begin
      miscompares++; $display("FAIL wr_word_bus: addr %h strb %b expected 00000100 1111", oAddr, oStrb);
    end
    vectors++;
    if (oWdata !== 32'hDEADBEEF || oWe !== 1'b1) begin
      miscompares++; $display("FAIL wr_word_data: wdata %h we %b expected deadbeef 1", oWdata, oWe);
    end
    run_txn(1'b0, 1'b1, 1'b0, 2'd0, 32'h103, 32'h000000AB, 32'h0, 1, 0,
            lat, reqCyc, oAddr, oWdata, oStrb, oWe, oValM, oFault, gotResp, respOne, idleReady, strayBus);
    vectors++;
    if (oWdata !== 32'hAB000000 || oStrb !== 4'b1000 || oAddr !== 32'h100) begin
      miscompares++; $display("FAIL wr_byte: wdata %h strb %b addr %h expected ab000000 1000 00000100", oWdata, oStrb, oAddr);
    end
    vectors++;
    if (lat !== 3 || reqCyc !== 2) begin miscompares++; $display("FAIL wr_byte_wait: lat %0d req %0d expected 3 2", lat, reqCyc); end
  endtask

  task automatic test_read();
    run_txn(1'b1, 1'b0, 1'b1, 2'd0, 32'h102, 32'h0, 32'h00800000, 0, 0,
            lat, reqCyc, oAddr, oWdata, oStrb, oWe, oValM, oFault, gotResp, respOne, idleReady, strayBus);
    vectors++;
    if (oValM !== 32'hFFFFFF80 || lat !== 3) begin
      miscompares++; $display("FAIL rd_sbyte: valM %h lat %0d expected ffffff80 3", oValM, lat);
    end
    run_txn(1'b1, 1'b0, 1'b0, 2'd0, 32'h102, 32'h0, 32'h00800000, 0, 2,
            lat, reqCyc, oAddr, oWdata, oStrb, oWe, oValM, oFault, gotResp, respOne, idleReady, strayBus);
    vectors++;
    if (oValM !== 32'h00000080 || lat !== 5 || oWe !== 1'b0) begin
      miscompares++; $display("FAIL rd_ubyte: valM %h lat %0d we %b expected 00000080 5 0", oValM, lat, oWe);
    end
  endtask

  task automatic test_fault_noop();
    run_txn(1'b1, 1'b0, 1'b0, 2'd1, 32'h101, 32'h0, 32'h0, 0, 0,
            lat, reqCyc, oAddr, oWdata, oStrb, oWe, oValM, oFault, gotResp, respOne, idleReady, strayBus);
    vectors++;
    if (lat !== 1 || oFault !== 1'b1 || reqCyc !== 0) begin
      miscompares++; $display("FAIL misaligned_half: lat %0d fault %b req %0d expected 1 1 0", lat, oFault, reqCyc);
    end
    run_txn(1'b1, 1'b1, 1'b0, 2'd2, 32'h200, 32'h0, 32'h0, 0, 0,
            lat, reqCyc, oAddr, oWdata, oStrb, oWe, oValM, oFault, gotResp, respOne, idleReady, strayBus);
    vectors++;
    if (lat !== 1 || oFault !== 1'b1 || reqCyc !== 0) begin
      miscompares++; $display("FAIL rd_and_wr: lat %0d fault %b req %0d expected 1 1 0", lat, oFault, reqCyc);
    end
    run_txn(1'b1, 1'b0, 1'b0, 2'd2, 32'h204, 32'h0, 32'h12345678, 0, 0,
            lat, reqCyc, oAddr, oWdata, oStrb, oWe, oValM, oFault, gotResp, respOne, idleReady, strayBus);
    run_txn(1'b0, 1'b0, 1'b0, 2'd2, 32'h300, 32'h0, 32'h0, 0, 0,
            lat, reqCyc, oAddr, oWdata, oStrb, oWe, oValM, oFault, gotResp, respOne, idleReady, strayBus);
    vectors++;
    if (lat !== 1 || oFault !== 1'b0 || oValM !== 32'd0 || reqCyc !== 0) begin
      miscompares++; $display("FAIL noop: lat %0d fault %b valM %h req %0d expected 1 0 0 0", lat, oFault, oValM, reqCyc);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 150; n++) begin
      int          sel, kind, gd, rvd, expLat;
      logic        rd, wr, sx;
      logic [1:0]  w;
      logic [31:0] a, wd, rdat;
      sel = $urandom_range(0, 9);
      rd = (sel == 1) || (sel >= 6);
      wr = (sel >= 1) && (sel <= 5);
      sx = 1'($urandom);
      w = 2'($urandom_range(0, 3));
      a = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
      wd = $urandom; rdat = $urandom;
      kind = model_kind(rd, wr, w, a);
      gd = (kind == 3) ? $urandom_range(0, MAX_GNT_RD) : $urandom_range(0, 3);
      rvd = $urandom_range(0, MAX_RV);
      expLat = (kind == 2) ? gd + 2 : (kind == 3) ? gd + rvd + 3 : 1;
      run_txn(rd, wr, sx, w, a, wd, rdat, gd, rvd,
              lat, reqCyc, oAddr, oWdata, oStrb, oWe, oValM, oFault, gotResp, respOne, idleReady, strayBus);
      vectors++;
      if (gotResp !== 1'b1) begin miscompares++; $display("FAIL rnd_resp[%0d]: no response within bound", n); continue; end
      vectors++;
      if (lat !== expLat) begin miscompares++; $display("FAIL rnd_lat[%0d]: got %0d expected %0d", n, lat, expLat); end
      vectors++;
      if (oFault !== (kind == 1)) begin miscompares++; $display("FAIL rnd_fault[%0d]: got %b expected %b", n, oFault, kind == 1); end
      vectors++;
      if (reqCyc !== ((kind >= 2) ? gd + 1 : 0)) begin
        miscompares++; $display("FAIL rnd_reqcyc[%0d]: got %0d expected %0d", n, reqCyc, (kind >= 2) ? gd + 1 : 0);
      end
      vectors++;
      if (respOne !== 1'b1 || idleReady !== 1'b1 || strayBus !== 1'b0) begin
        miscompares++; $display("FAIL rnd_handshake[%0d]: one %b ready %b stray %b expected 1 1 0", n, respOne, idleReady, strayBus);
      end
      if (kind == 0 || kind == 3) begin
        vectors++;
        if (oValM !== ((kind == 3) ? model_load(rdat, w, sx, a) : 32'd0)) begin
          miscompares++; $display("FAIL rnd_valM[%0d]: got %h expected %h", n, oValM, (kind == 3) ? model_load(rdat, w, sx, a) : 32'd0);
        end
      end
      if (kind >= 2) begin
        vectors++;
        if (oAddr !== (a & 32'hFFFF_FFFC) || oWe !== (kind == 2)) begin
          miscompares++; $display("FAIL rnd_bus[%0d]: addr %h we %b expected %h %b", n, oAddr, oWe, a & 32'hFFFF_FFFC, kind == 2);
        end
      end
      if (kind == 2) begin
        vectors++;
        if (oStrb !== model_strb(w, a) || oWdata !== model_wdata(wd, a)) begin
          miscompares++; $display("FAIL rnd_wr[%0d]: strb %b wdata %h expected %b %h", n, oStrb, oWdata, model_strb(w, a), model_wdata(wd, a));
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic sawResp;
    sawResp = 1'b0;
    @(negedge clk);
    mem_read_en = 1'b1; mem_write_en = 1'b0; mem_width = 2'd2; addr = 32'h400; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    rst = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || valM !== 32'd0) begin
      miscompares++; $display("FAIL rst_wait_async: ready %b resp %b valM %h expected 1 0 0", req_ready, resp_valid, valM);
    end
    @(negedge clk);
    rst = 1'b0; bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = $urandom;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid || bus_req || !req_ready) sawResp = 1'b1;
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    vectors++;
    if (sawResp !== 1'b0 || valM !== 32'd0) begin
      miscompares++; $display("FAIL rst_wait_idle: activity %b valM %h expected 0 0", sawResp, valM);
    end
  endtask

`ifdef MEMORY_STAGE_TIMEOUT_EN
  task automatic test_timeout();
    run_txn(1'b0, 1'b1, 1'b0, 2'd2, 32'h500, 32'h11111111, 32'h0, 1000, 0,
            lat, reqCyc, oAddr, oWdata, oStrb, oWe, oValM, oFault, gotResp, respOne, idleReady, strayBus);
    vectors++;
    if (gotResp !== 1'b1 || lat !== TO + 1 || oFault !== 1'b1 || reqCyc !== TO || oValM !== 32'd0) begin
      miscompares++; $display("FAIL timeout_req: resp %b lat %0d fault %b req %0d valM %h expected 1 %0d 1 %0d 0", gotResp, lat, oFault, reqCyc, oValM, TO + 1, TO);
    end
    run_txn(1'b1, 1'b0, 1'b0, 2'd2, 32'h504, 32'h0, 32'h22222222, 0, 1000,
            lat, reqCyc, oAddr, oWdata, oStrb, oWe, oValM, oFault, gotResp, respOne, idleReady, strayBus);
    vectors++;
    if (gotResp !== 1'b1 || lat !== TO + 1 || oFault !== 1'b1 || oValM !== 32'd0) begin
      miscompares++; $display("FAIL timeout_wait: resp %b lat %0d fault %b valM %h expected 1 %0d 1 0", gotResp, lat, oFault, oValM, TO + 1);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_fault_noop();
    test_random();
    test_reset_mid_wait();
`ifdef MEMORY_STAGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
